rom_load_controller: RTL and testbench

Top-level sequencer for ROM image loading. Holds the target CPU in reset, runs the flash reader for the selected image (cfg_select), and supervises completion with timeout and retry. Owns the shared RAM port: the loader drives it during loading, the CPU bus drives it while running. Sits between the config DIP switches, the flash reader, the RAM and the CPU reset/bus pins.

---
 rtl/rom_load_pkg.sv | 26 ++
 rtl/cfg_debounce.sv | 47 ++++
 rtl/rom_load_controller.sv | 196 +++++++++++++++++++
 tb/tb_rom_load_controller.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_load_pkg.sv
// Shared types and constants for the ROM load controller: state encoding,
// default timing parameters and RAM-port field widths.
package rom_load_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int CFG_W  = 5;

  localparam int DEF_SETTLE_CYCLES     = 1024;
  localparam int DEF_RESET_HOLD_CYCLES = 16;
  localparam int DEF_TIMEOUT_CYCLES    = 2**22;
  localparam int DEF_MAX_RETRIES       = 2;

  // The reader's done level can still be high from the previous run for this
  // many cycles after it is released.
  localparam int DONE_IGNORE_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_SETTLE  = 3'd0,
    ST_LOADING = 3'd1,
    ST_HOLD    = 3'd2,
    ST_RUN     = 3'd3,
    ST_FAIL    = 3'd4
  } state_t;

endpackage

// File: rtl/cfg_debounce.sv
// Two-flop synchroniser for the config switches plus a stability counter that
// runs only while enabled and restarts whenever the synchronised value changes.
module cfg_debounce
  import rom_load_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic [CFG_W-1:0] cfg_select,
  input  logic             enable,
  output logic [CFG_W-1:0] cfg_value,
  output logic             cfg_stable
);

  localparam int CW = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  logic [CFG_W-1:0] sync_meta_reg;
  logic [CFG_W-1:0] sync_out_reg;
  logic [CFG_W-1:0] prev_reg;
  logic [CW-1:0]    cnt_reg;
  logic             changed;

  assign changed = (sync_out_reg != prev_reg);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sync_meta_reg <= '0;
      sync_out_reg  <= '0;
      prev_reg      <= '0;
      cnt_reg       <= '0;
    end else begin
      sync_meta_reg <= cfg_select;
      sync_out_reg  <= sync_meta_reg;
      prev_reg      <= sync_out_reg;
      if (!enable || changed)
        cnt_reg <= '0;
      else if (cnt_reg != CNT_LAST)
        cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cfg_value  = sync_out_reg;
  assign cfg_stable = enable && !changed && (cnt_reg == CNT_LAST);

endmodule

// File: rtl/rom_load_controller.sv
// Boot sequencer: settles the image select, runs the flash reader with
// timeout/retry, holds the CPU in reset and arbitrates the shared RAM port.
module rom_load_controller
  import rom_load_pkg::*;
#(
  parameter int SETTLE_CYCLES     = DEF_SETTLE_CYCLES,
  parameter int RESET_HOLD_CYCLES = DEF_RESET_HOLD_CYCLES,
  parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES       = DEF_MAX_RETRIES
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic [CFG_W-1:0]  cfg_select,
  input  logic              reload_req,
  output logic              ldr_rst_l,
  output logic [CFG_W-1:0]  ldr_read_addr,
  input  logic              ldr_done,
  input  logic [ADDR_W-1:0] ldr_ram_address,
  input  logic [DATA_W-1:0] ldr_ram_data,
  input  logic              ldr_ram_cs,
  input  logic              ldr_ram_we,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_datain,
  output logic              ram_cs,
  output logic              ram_we,
  output logic              cpu_reset_l,
  output logic              busy,
  output logic              load_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int HW = $clog2(RESET_HOLD_CYCLES) + 1;
  localparam int RW = $clog2(MAX_RETRIES + 1) + 1;
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_IGNORE = TW'(DONE_IGNORE_CYCLES);
  localparam logic [HW-1:0] H_LAST   = HW'(RESET_HOLD_CYCLES - 1);
  localparam logic [RW-1:0] R_MAX    = RW'(MAX_RETRIES);

  state_t           state_reg, state_next;
  logic [TW-1:0]    tcnt_reg, tcnt_next;
  logic [HW-1:0]    hcnt_reg, hcnt_next;
  logic [RW-1:0]    retry_reg, retry_next;
  logic             gap_reg, gap_next;
  logic             ldr_rst_reg, ldr_rst_next;
  logic [CFG_W-1:0] read_addr_reg, read_addr_next;
  logic             cpu_rst_reg, cpu_rst_next;
  logic [ADDR_W-1:0] addr_hold_reg;
  logic [DATA_W-1:0] data_hold_reg;

  logic             settle_en;
  logic [CFG_W-1:0] cfg_value;
  logic             cfg_stable;

  assign settle_en = (state_reg == ST_SETTLE);

  cfg_debounce #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .rst_l     (rst_l),
    .cfg_select(cfg_select),
    .enable    (settle_en),
    .cfg_value (cfg_value),
    .cfg_stable(cfg_stable)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_reg     <= ST_SETTLE;
      tcnt_reg      <= '0;
      hcnt_reg      <= '0;
      retry_reg     <= '0;
      gap_reg       <= 1'b0;
      ldr_rst_reg   <= 1'b0;
      read_addr_reg <= '0;
      cpu_rst_reg   <= 1'b0;
      addr_hold_reg <= '0;
      data_hold_reg <= '0;
    end else begin
      state_reg     <= state_next;
      tcnt_reg      <= tcnt_next;
      hcnt_reg      <= hcnt_next;
      retry_reg     <= retry_next;
      gap_reg       <= gap_next;
      ldr_rst_reg   <= ldr_rst_next;
      read_addr_reg <= read_addr_next;
      cpu_rst_reg   <= cpu_rst_next;
      addr_hold_reg <= ram_address;
      data_hold_reg <= ram_datain;
    end
  end

  always_comb begin
    state_next     = state_reg;
    tcnt_next      = tcnt_reg;
    hcnt_next      = hcnt_reg;
    retry_next     = retry_reg;
    gap_next       = gap_reg;
    ldr_rst_next   = ldr_rst_reg;
    read_addr_next = read_addr_reg;
    cpu_rst_next   = cpu_rst_reg;
    case (state_reg)
      ST_SETTLE: begin
        cpu_rst_next = 1'b0;
        ldr_rst_next = 1'b0;
        if (cfg_stable) begin
          read_addr_next = cfg_value;
          tcnt_next      = '0;
          gap_next       = 1'b0;
          ldr_rst_next   = 1'b1;
          state_next     = ST_LOADING;
        end
      end
      ST_LOADING: begin
        // gap_reg marks the single idle cycle that restarts the reader on a retry
        if (gap_reg) begin
          gap_next     = 1'b0;
          ldr_rst_next = 1'b1;
          tcnt_next    = '0;
        end else if (ldr_done && (tcnt_reg >= T_IGNORE)) begin
          ldr_rst_next = 1'b0;
          hcnt_next    = '0;
          state_next   = ST_HOLD;
        end else if (tcnt_reg == T_LAST) begin
          ldr_rst_next = 1'b0;
          if (retry_reg >= R_MAX) begin
            state_next = ST_FAIL;
          end else begin
            retry_next = retry_reg + 1'b1;
            gap_next   = 1'b1;
          end
        end else begin
          tcnt_next = tcnt_reg + 1'b1;
        end
      end
      ST_HOLD: begin
        if (hcnt_reg == H_LAST) begin
          cpu_rst_next = 1'b1;
          retry_next   = '0;
          state_next   = ST_RUN;
        end else begin
          hcnt_next = hcnt_reg + 1'b1;
        end
      end
      ST_RUN: begin
        if (reload_req || (cfg_value != read_addr_reg)) begin
          cpu_rst_next = 1'b0;
          state_next   = ST_SETTLE;
        end
      end
      ST_FAIL: begin
        ldr_rst_next = 1'b0;
        cpu_rst_next = 1'b0;
        if (reload_req) begin
          retry_next = '0;
          state_next = ST_SETTLE;
        end
      end
      default: state_next = ST_SETTLE;
    endcase
  end

  // Idle states park address/data on whatever was last driven.
  always_comb begin
    ram_cs      = 1'b0;
    ram_we      = 1'b0;
    ram_address = addr_hold_reg;
    ram_datain  = data_hold_reg;
    case (state_reg)
      ST_LOADING: begin
        ram_cs      = ldr_ram_cs;
        ram_we      = ldr_ram_we;
        ram_address = ldr_ram_address;
        ram_datain  = ldr_ram_data;
      end
      ST_RUN: begin
        ram_cs      = cpu_cs;
        ram_we      = cpu_we;
        ram_address = cpu_address;
        ram_datain  = cpu_wdata;
      end
      default: ;
    endcase
  end

  assign ldr_rst_l     = ldr_rst_reg;
  assign ldr_read_addr = read_addr_reg;
  assign cpu_reset_l   = cpu_rst_reg;
  assign busy          = (state_reg != ST_RUN) && (state_reg != ST_FAIL);
  assign load_error    = (state_reg == ST_FAIL);

endmodule

// File: tb/tb_rom_load_controller.sv
// Randomised self-checking bench for rom_load_controller with a reduced
// timeout so the retry/fail path finishes quickly.
module tb_rom_load_controller;

  localparam int SETTLE  = 1024;
  localparam int HOLD    = 16;
  localparam int TMO     = 512;
  localparam int RETRIES = 2;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic [4:0]  cfg_select = '0;
  logic        reload_req = 1'b0;
  logic        ldr_rst_l;
  logic [4:0]  ldr_read_addr;
  logic        ldr_done = 1'b0;
  logic [15:0] ldr_ram_address = '0;
  logic [7:0]  ldr_ram_data = '0;
  logic        ldr_ram_cs = 1'b0;
  logic        ldr_ram_we = 1'b0;
  logic [15:0] cpu_address = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_cs = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] ram_address;
  logic [7:0]  ram_datain;
  logic        ram_cs;
  logic        ram_we;
  logic        cpu_reset_l;
  logic        busy;
  logic        load_error;

  int n_checks = 0;
  int n_fail   = 0;

  // Last address/data the RAM port carried; idle states must repeat it.
  logic [15:0] model_addr = '0;
  logic [7:0]  model_data = '0;

  rom_load_controller #(
    .SETTLE_CYCLES    (SETTLE),
    .RESET_HOLD_CYCLES(HOLD),
    .TIMEOUT_CYCLES   (TMO),
    .MAX_RETRIES      (RETRIES)
  ) dut (
    .clk            (clk),
    .rst_l          (rst_l),
    .cfg_select     (cfg_select),
    .reload_req     (reload_req),
    .ldr_rst_l      (ldr_rst_l),
    .ldr_read_addr  (ldr_read_addr),
    .ldr_done       (ldr_done),
    .ldr_ram_address(ldr_ram_address),
    .ldr_ram_data   (ldr_ram_data),
    .ldr_ram_cs     (ldr_ram_cs),
    .ldr_ram_we     (ldr_ram_we),
    .cpu_address    (cpu_address),
    .cpu_wdata      (cpu_wdata),
    .cpu_cs         (cpu_cs),
    .cpu_we         (cpu_we),
    .ram_address    (ram_address),
    .ram_datain     (ram_datain),
    .ram_cs         (ram_cs),
    .ram_we         (ram_we),
    .cpu_reset_l    (cpu_reset_l),
    .busy           (busy),
    .load_error     (load_error)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic drive_traffic();
    ldr_ram_address = 16'($urandom);
    ldr_ram_data    = 8'($urandom);
    ldr_ram_cs      = 1'($urandom);
    ldr_ram_we      = 1'($urandom);
    cpu_address     = 16'($urandom);
    cpu_wdata       = 8'($urandom);
    cpu_cs          = 1'($urandom);
    cpu_we          = 1'($urandom);
  endtask

  // mode 0: nobody owns the port; 1: loader owns it; 2: CPU owns it.
  task automatic ram_model(input int mode, output logic [25:0] exp_port);
    logic [15:0] a;
    logic [7:0]  d;
    logic        cs, we;
    if (mode == 1) begin
      a = ldr_ram_address; d = ldr_ram_data; cs = ldr_ram_cs; we = ldr_ram_we;
    end else if (mode == 2) begin
      a = cpu_address; d = cpu_wdata; cs = cpu_cs; we = cpu_we;
    end else begin
      a = model_addr; d = model_data; cs = 1'b0; we = 1'b0;
    end
    model_addr = a;
    model_data = d;
    exp_port = {cs, we, a, d};
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload_req = 1'b1;
    @(negedge clk);
    reload_req = 1'b0;
    #1;
    n_checks++;
    if ({cpu_reset_l, busy, ram_cs} !== 3'b010) begin
      n_fail++;
      $display("FAIL reload_entry got cpu_reset_l/busy/ram_cs=%b want 010", {cpu_reset_l, busy, ram_cs});
    end
  endtask

  // One complete load: wait for the reader to be released, run it with random
  // RAM traffic, complete at done_delay, then verify the CPU reset hold.
  task automatic load_cycle(input logic [4:0] exp_addr, input int done_delay,
                            input int wmin, input int wmax);
    int w, h;
    logic [25:0] exp_port;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (ldr_rst_l !== 1'b1 && w < wmax + 10);
    n_checks++;
    if (w < wmin || w > wmax) begin
      n_fail++;
      $display("FAIL settle_wait got %0d cycles want %0d..%0d", w, wmin, wmax);
    end
    n_checks++;
    if (ldr_read_addr !== exp_addr) begin
      n_fail++;
      $display("FAIL read_addr got %0d want %0d", ldr_read_addr, exp_addr);
    end
    for (int n = 0; n <= done_delay; n++) begin
      if (n > 0) @(negedge clk);
      drive_traffic();
      if (n == 1) begin
        ldr_ram_address = 16'h1234; ldr_ram_data = 8'hA5; ldr_ram_cs = 1'b1; ldr_ram_we = 1'b1;
        cpu_address = 16'hFFFF; cpu_cs = 1'b1; cpu_we = 1'b1;
      end
      if (n == 2) ldr_done = 1'b0;
      if (n == done_delay) ldr_done = 1'b1;
      #1;
      ram_model(1, exp_port);
      n_checks++;
      if ({ram_cs, ram_we, ram_address, ram_datain} !== exp_port) begin
        n_fail++;
        $display("FAIL ram_loading n=%0d got %h want %h", n, {ram_cs, ram_we, ram_address, ram_datain}, exp_port);
      end
      n_checks++;
      if ({ldr_rst_l, cpu_reset_l, busy} !== 3'b101) begin
        n_fail++;
        $display("FAIL loading_flags n=%0d got ldr_rst_l/cpu_reset_l/busy=%b want 101", n, {ldr_rst_l, cpu_reset_l, busy});
      end
    end
    @(negedge clk);
    drive_traffic();
    #1;
    n_checks++;
    if (ldr_rst_l !== 1'b0) begin
      n_fail++;
      $display("FAIL done_accept got ldr_rst_l=%b want 0", ldr_rst_l);
    end
    ram_model(0, exp_port);
    n_checks++;
    if ({ram_cs, ram_we, ram_address, ram_datain} !== exp_port) begin
      n_fail++;
      $display("FAIL ram_hold_entry got %h want %h", {ram_cs, ram_we, ram_address, ram_datain}, exp_port);
    end
    h = 0;
    while (cpu_reset_l !== 1'b1 && h < HOLD + 8) begin
      @(negedge clk);
      drive_traffic();
      #1;
      h++;
      if (cpu_reset_l !== 1'b1) begin
        ram_model(0, exp_port);
        n_checks++;
        if ({ram_cs, ram_we, ram_address, ram_datain} !== exp_port) begin
          n_fail++;
          $display("FAIL ram_hold h=%0d got %h want %h", h, {ram_cs, ram_we, ram_address, ram_datain}, exp_port);
        end
      end
    end
    n_checks++;
    if (h !== HOLD) begin
      n_fail++;
      $display("FAIL hold_cycles got %0d want %0d", h, HOLD);
    end
    n_checks++;
    if ({busy, load_error, ldr_rst_l} !== 3'b000) begin
      n_fail++;
      $display("FAIL run_flags got busy/load_error/ldr_rst_l=%b want 000", {busy, load_error, ldr_rst_l});
    end
    ram_model(2, exp_port);
    n_checks++;
    if ({ram_cs, ram_we, ram_address, ram_datain} !== exp_port) begin
      n_fail++;
      $display("FAIL ram_run_entry got %h want %h", {ram_cs, ram_we, ram_address, ram_datain}, exp_port);
    end
    $display("load addr=%0d done_delay=%0d settle_wait=%0d hold=%0d", exp_addr, done_delay, w, h);
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    cfg_select = 5'd5;
    drive_traffic();
    cpu_cs = 1'b1;
    ldr_ram_cs = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    model_addr = '0;
    model_data = '0;
    n_checks++;
    if ({ldr_rst_l, cpu_reset_l, ram_cs, ram_we, busy, load_error} !== 6'b000010) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 000010", {ldr_rst_l, cpu_reset_l, ram_cs, ram_we, busy, load_error});
    end
    n_checks++;
    if ({ldr_read_addr, ram_address, ram_datain} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_values got %h want 0", {ldr_read_addr, ram_address, ram_datain});
    end
    $display("reset checked");
  endtask

  task automatic test_first_load();
    @(negedge clk);
    rst_l = 1'b1;
    load_cycle(5'd5, 300, SETTLE, SETTLE + 8);
  endtask

  task automatic test_run_mux();
    logic [25:0] exp_port;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      drive_traffic();
      if (i == 0) begin
        cpu_address = 16'hFFFF; cpu_cs = 1'b1;
        ldr_ram_address = 16'h1234; ldr_ram_data = 8'hA5; ldr_ram_cs = 1'b1; ldr_ram_we = 1'b1;
      end
      #1;
      ram_model(2, exp_port);
      n_checks++;
      if ({ram_cs, ram_we, ram_address, ram_datain} !== exp_port) begin
        n_fail++;
        $display("FAIL ram_run i=%0d got %h want %h", i, {ram_cs, ram_we, ram_address, ram_datain}, exp_port);
      end
    end
    $display("run mux checked 40 cycles");
  endtask

  // Change cfg in RUN and check the CPU is put back in reset promptly with
  // the CPU's RAM select dropped on the same edge.
  task automatic cfg_leave_run(input logic [4:0] new_cfg);
    int d;
    logic [25:0] exp_port;
    @(negedge clk);
    drive_traffic();
    cpu_cs = 1'b1;
    #1;
    ram_model(2, exp_port);
    cfg_select = new_cfg;
    d = 0;
    do begin
      @(negedge clk);
      d++;
    end while (cpu_reset_l === 1'b1 && d < 10);
    n_checks++;
    if (d < 2 || d > 4) begin
      n_fail++;
      $display("FAIL cfg_detect got %0d cycles want 2..4", d);
    end
    n_checks++;
    if ({ram_cs, ram_address} !== {1'b0, model_addr}) begin
      n_fail++;
      $display("FAIL ram_cs_drop got cs=%b a=%h want cs=0 a=%h", ram_cs, ram_address, model_addr);
    end
    $display("cfg change to %0d detected after %0d cycles", new_cfg, d);
  endtask

  task automatic test_cfg_change();
    cfg_leave_run(5'd3);
    load_cycle(5'd3, int'($urandom_range(200, 20)), SETTLE - 4, SETTLE + 8);
    cfg_leave_run(5'd7);
    repeat (30) @(negedge clk);
    cfg_select = 5'd3;
    repeat (40) @(negedge clk);
    cfg_select = 5'd7;
    load_cycle(5'd7, int'($urandom_range(200, 20)), SETTLE, SETTLE + 8);
  endtask

  task automatic test_stale_done();
    // ldr_done is still high from the previous load when the reader restarts
    pulse_reload();
    load_cycle(5'd7, 50, SETTLE - 4, SETTLE + 8);
  endtask

  task automatic test_timeout_retry();
    int w, hi, lo;
    logic [25:0] exp_port;
    ldr_done = 1'b0;
    pulse_reload();
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (ldr_rst_l !== 1'b1 && w < SETTLE + 20);
    for (int a = 0; a <= RETRIES; a++) begin
      hi = 1;
      forever begin
        @(negedge clk);
        drive_traffic();
        #1;
        if (ldr_rst_l !== 1'b1 || hi >= TMO + 20) break;
        hi++;
        ram_model(1, exp_port);
        n_checks++;
        if ({ram_cs, ram_we, ram_address, ram_datain} !== exp_port) begin
          n_fail++;
          $display("FAIL ram_retry a=%0d got %h want %h", a, {ram_cs, ram_we, ram_address, ram_datain}, exp_port);
        end
      end
      n_checks++;
      if (hi !== TMO) begin
        n_fail++;
        $display("FAIL attempt_len a=%0d got %0d want %0d", a, hi, TMO);
      end
      if (a < RETRIES) begin
        ram_model(1, exp_port);
        lo = 1;
        forever begin
          @(negedge clk);
          #1;
          if (ldr_rst_l === 1'b1 || lo >= 5) break;
          lo++;
        end
        n_checks++;
        if ({lo, load_error, busy} !== {32'd1, 1'b0, 1'b1}) begin
          n_fail++;
          $display("FAIL retry_gap a=%0d got low=%0d load_error=%b busy=%b want 1 0 1", a, lo, load_error, busy);
        end
      end else begin
        ram_model(0, exp_port);
        n_checks++;
        if ({ram_cs, ram_we, ram_address, ram_datain} !== exp_port) begin
          n_fail++;
          $display("FAIL ram_fail got %h want %h", {ram_cs, ram_we, ram_address, ram_datain}, exp_port);
        end
      end
      $display("attempt %0d high for %0d cycles", a, hi);
    end
    n_checks++;
    if ({load_error, cpu_reset_l, busy, ldr_rst_l} !== 4'b1000) begin
      n_fail++;
      $display("FAIL fail_state got load_error/cpu_reset_l/busy/ldr_rst_l=%b want 1000", {load_error, cpu_reset_l, busy, ldr_rst_l});
    end
    cfg_select = 5'd12;
    repeat (20) @(negedge clk);
    #1;
    n_checks++;
    if ({load_error, ram_cs, ldr_rst_l} !== 3'b100) begin
      n_fail++;
      $display("FAIL fail_sticky got load_error/ram_cs/ldr_rst_l=%b want 100", {load_error, ram_cs, ldr_rst_l});
    end
    pulse_reload();
    n_checks++;
    if (load_error !== 1'b0) begin
      n_fail++;
      $display("FAIL fail_clear got load_error=%b want 0", load_error);
    end
    load_cycle(5'd12, 100, SETTLE - 4, SETTLE + 8);
  endtask

  task automatic test_async_reset();
    int w;
    ldr_done = 1'b0;
    pulse_reload();
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (ldr_rst_l !== 1'b1 && w < SETTLE + 20);
    repeat (10) begin
      @(negedge clk);
      drive_traffic();
      ldr_ram_cs = 1'b1;
    end
    #1;
    n_checks++;
    if (ram_cs !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_cs got %b want 1", ram_cs);
    end
    #1;
    rst_l = 1'b0;
    #1;
    model_addr = '0;
    model_data = '0;
    n_checks++;
    if ({ldr_rst_l, cpu_reset_l, ram_cs, ram_we, busy, load_error} !== 6'b000010) begin
      n_fail++;
      $display("FAIL async_reset_flags got %b want 000010", {ldr_rst_l, cpu_reset_l, ram_cs, ram_we, busy, load_error});
    end
    n_checks++;
    if ({ldr_read_addr, ram_address, ram_datain} !== 29'd0) begin
      n_fail++;
      $display("FAIL async_reset_values got %h want 0", {ldr_read_addr, ram_address, ram_datain});
    end
    @(negedge clk);
    rst_l = 1'b1;
    load_cycle(5'd12, 60, SETTLE, SETTLE + 8);
  endtask

  initial begin
    test_reset();
    test_first_load();
    test_run_mux();
    test_cfg_change();
    test_stale_done();
    test_timeout_retry();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
